// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU/debug arbiter for one data-memory port with starvation force.
// Define DMEM_ARB_RR_EN for round-robin on contention; fixed CPU priority otherwise.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [13:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic [13:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_spo
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       last_owner;
    logic       forced;
    logic       dbg_win;
    logic       cpu_gnt;

    assign cpu_rdata = mem_spo;

    // Grant decision and memory steering; reset masks every strobe so no write commits mid-reset
    always_comb begin
        forced = dbg_req && starve_cnt == LIMIT;
`ifdef DMEM_ARB_RR_EN
        dbg_win = dbg_req && (!cpu_req || forced || !last_owner);
`else
        dbg_win = dbg_req && (!cpu_req || forced);
`endif
        cpu_gnt = cpu_req && !dbg_win;
        dbg_gnt = rst_n && dbg_win;
        cpu_stall = rst_n && cpu_req && !cpu_gnt;
        mem_a = dbg_gnt ? dbg_addr : cpu_addr;
        mem_d = dbg_gnt ? dbg_wdata : cpu_wdata;
        mem_we = rst_n && (dbg_win ? dbg_we : cpu_gnt && cpu_we);
    end

    // Starvation counter, grant history and registered debug read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            last_owner <= 1'b0;
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            starve_cnt <= (!dbg_req || dbg_gnt) ? 4'd0 : (starve_cnt == LIMIT ? starve_cnt : starve_cnt + 4'd1);
            last_owner <= (dbg_gnt || cpu_gnt) ? dbg_gnt : last_owner;
            dbg_rvalid <= dbg_gnt && !dbg_we;
            dbg_rdata  <= (dbg_gnt && !dbg_we) ? mem_spo : dbg_rdata;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a behavioural RAM.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [13:0] cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_d, mem_spo;
    logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_we;
    logic [13:0] mem_a;
    logic [31:0] mem [0:16383];
    int          checks = 0;
    int          failures = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    assign mem_spo = mem[mem_a];

    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic req, input logic we, input logic [13:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dbg(input logic req, input logic we, input logic [13:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        mem[14'h020] = 32'h12345678;
        mem[14'h030] = 32'hA5A5A5A5;
        rst_n = 1'b0;
        cpu(1, 1, 14'h010, 32'hCAFEF00D);
        dbg(1, 1, 14'h030, 32'hFFFFFFFF);
        cyc();
        cyc();
        #3;
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
        cyc();
        cpu(0, 0, 14'h0, 32'h0);
        dbg(0, 0, 14'h0, 32'h0);
        rst_n = 1'b1;
        cyc();
        // CPU store alone
        cpu(1, 1, 14'h010, 32'hDEADBEEF);
        #3;
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_stall", 32'(cpu_stall), 32'd0);
        chk("st_mem_a", 32'(mem_a), 32'h010);
        chk("st_mem_d", mem_d, 32'hDEADBEEF);
        cyc();
        // CPU load of the same word
        cpu(1, 0, 14'h010, 32'h0);
        #3;
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_stall", 32'(cpu_stall), 32'd0);
        chk("ld_mem_we", 32'(mem_we), 32'd0);
        cyc();
        // Debug read with CPU idle
        cpu(0, 0, 14'h0, 32'h0);
        dbg(1, 0, 14'h020, 32'h0);
        #3;
        chk("dr_gnt", 32'(dbg_gnt), 32'd1);
        chk("dr_mem_a", 32'(mem_a), 32'h020);
        chk("dr_rvalid_n", 32'(dbg_rvalid), 32'd0);
        cyc();
        dbg(0, 0, 14'h0, 32'h0);
        #3;
        chk("dr_rvalid_n1", 32'(dbg_rvalid), 32'd1);
        chk("dr_rdata_n1", dbg_rdata, 32'h12345678);
        cyc();
        #3;
        chk("dr_rvalid_n2", 32'(dbg_rvalid), 32'd0);
        cyc();
        // Back-to-back debug: write then read, write gives no rvalid
        dbg(1, 1, 14'h040, 32'h11111111);
        #3;
        chk("bb_w_gnt", 32'(dbg_gnt), 32'd1);
        chk("bb_w_we", 32'(mem_we), 32'd1);
        chk("bb_w_d", mem_d, 32'h11111111);
        cyc();
        dbg(1, 0, 14'h040, 32'h0);
        #3;
        chk("bb_r_gnt", 32'(dbg_gnt), 32'd1);
        chk("bb_w_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("bb_last_owner", 32'(dut.last_owner), 32'd1);
        cyc();
        dbg(0, 0, 14'h0, 32'h0);
        #3;
        chk("bb_r_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("bb_r_rdata", dbg_rdata, 32'h11111111);
        cyc();
        // CPU-only access leaves last_owner=0
        cpu(1, 0, 14'h010, 32'h0);
        cyc();
        #3;
        chk("cpu_last_owner", 32'(dut.last_owner), 32'd0);
        // Continuous contention
        dbg(1, 0, 14'h020, 32'h0);
        for (int i = 0; i < 10; i++) begin
            logic exp_dbg;
`ifdef DMEM_ARB_RR_EN
            exp_dbg = (i % 2) == 0;
`else
            exp_dbg = (i % 5) == 4;
`endif
            #3;
            chk($sformatf("ct_gnt_%0d", i), 32'(dbg_gnt), 32'(exp_dbg));
            chk($sformatf("ct_stall_%0d", i), 32'(cpu_stall), 32'(exp_dbg));
            chk($sformatf("ct_mem_a_%0d", i), 32'(mem_a), exp_dbg ? 32'h020 : 32'h010);
            cyc();
        end
        cpu(0, 0, 14'h0, 32'h0);
        dbg(0, 0, 14'h0, 32'h0);
        cyc();
        // Reset dropped mid-cycle during a debug write
        dbg(1, 0, 14'h020, 32'h0);
        cyc();
        dbg(1, 1, 14'h030, 32'hFFFFFFFF);
        #2;
        chk("rw_rvalid_pre", 32'(dbg_rvalid), 32'd1);
        chk("rw_mem_we_pre", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_mem_we_rst", 32'(mem_we), 32'd0);
        chk("rw_gnt_rst", 32'(dbg_gnt), 32'd0);
        chk("rw_rvalid_rst", 32'(dbg_rvalid), 32'd0);
        cyc();
        dbg(0, 0, 14'h0, 32'h0);
        cyc();
        rst_n = 1'b1;
        #3;
        chk("rw_mem_30", mem[14'h030], 32'hA5A5A5A5);
        chk("rw_rvalid_rel", 32'(dbg_rvalid), 32'd0);
        chk("rw_starve_rel", 32'(dut.starve_cnt), 32'd0);
        cyc();
        // First access after release arbitrates normally
        dbg(1, 0, 14'h030, 32'h0);
        #3;
        chk("post_gnt", 32'(dbg_gnt), 32'd1);
        cyc();
        dbg(0, 0, 14'h0, 32'h0);
        #3;
        chk("post_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("post_rdata", dbg_rdata, 32'hA5A5A5A5);
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
